// File: rtl/spart_pkg.sv
// Shared SPART definitions: tx state encoding
// and frame constants common to both serial paths.
package spart_pkg;

    localparam int   DATA_BITS     = 8;
    localparam int   TICKS_PER_BIT = 16;
    localparam logic IDLE_LEVEL    = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Baud tick counter for the transmitter: pulses
// bit_done on the Baud tick that completes a bit.
module uart_tx_bit_timer #(
    parameter int CW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          Baud,
    input  logic          clr,
    input  logic [CW-1:0] target,
    output logic          bit_done
);

    logic [CW-1:0] cnt;

    assign bit_done = Baud & ~clr &
                      (cnt == target - CW'(1));

    // Count Baud ticks; restart on clear or at each bit boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || bit_done) begin
            cnt <= '0;
        end else if (Baud) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 serial transmitter with a one-entry holding
// buffer so frames can be sent back to back.
module uart_tx #(
    parameter int DATA_BITS     = spart_pkg::DATA_BITS,
    parameter int TICKS_PER_BIT = spart_pkg::TICKS_PER_BIT,
    parameter int STOP_BITS     = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 Baud,
    input  logic [DATA_BITS-1:0] TxD_data,
    input  logic                 wr_tx,
    output logic                 TxD,
    output logic                 TBR,
    output logic                 tx_busy
);

    import spart_pkg::*;

    localparam int CW = $clog2(TICKS_PER_BIT * STOP_BITS) + 1;
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    tx_state_t            state;
    tx_state_t            state_nx;
    logic [DATA_BITS-1:0] hold_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 hold_full;
    logic [BW-1:0]        bit_cnt;
    logic                 txd_q;
    logic                 load;
    logic                 clr;
    logic                 bit_done;
    logic [CW-1:0]        target;

    uart_tx_bit_timer #(
        .CW(CW)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .Baud    (Baud),
        .clr     (clr),
        .target  (target),
        .bit_done(bit_done)
    );

    // Next state, shifter load and bit length selection
    always_comb begin
        state_nx = state;
        load     = 1'b0;
        clr      = 1'b0;
        target   = CW'(TICKS_PER_BIT);
        unique case (state)
            IDLE: begin
                clr = 1'b1;
                if (hold_full) begin
                    load     = 1'b1;
                    state_nx = START;
                end
            end
            START: begin
                if (bit_done) state_nx = DATA;
            end
            DATA: begin
                if (bit_done &&
                    bit_cnt == BW'(DATA_BITS - 1))
                    state_nx = STOP;
            end
            STOP: begin
                target = CW'(STOP_BITS * TICKS_PER_BIT);
                if (bit_done) begin
                    if (hold_full) begin
                        load     = 1'b1;
                        state_nx = START;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Holding register: accept a write only while empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q    <= '0;
            hold_full <= 1'b0;
        end else if (load) begin
            hold_q    <= '0;
            hold_full <= 1'b0;
        end else if (wr_tx && !hold_full) begin
            hold_q    <= TxD_data;
            hold_full <= 1'b1;
        end
    end

    // Shifter and data bit counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            bit_cnt <= '0;
        end else if (load) begin
            shift_q <= hold_q;
            bit_cnt <= '0;
        end else if (state == DATA && bit_done) begin
            shift_q <= shift_q >> 1;
            bit_cnt <= bit_cnt + BW'(1);
        end
    end

    // Registered line driver, one cycle behind the state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txd_q <= IDLE_LEVEL;
        end else begin
            unique case (state)
                START:   txd_q <= 1'b0;
                DATA:    txd_q <= shift_q[0];
                default: txd_q <= IDLE_LEVEL;
            endcase
        end
    end

    assign TxD     = txd_q;
    assign TBR     = ~hold_full;
    assign tx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: reset, framing,
// baud division, back to back, overrun, 2 stop bits.
module tb_uart_tx;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       Baud      = 1'b0;
    logic [7:0] TxD_data  = 8'h00;
    logic [7:0] TxD_data2 = 8'h00;
    logic       wr_tx     = 1'b0;
    logic       wr_tx2    = 1'b0;
    logic       TxD;
    logic       TBR;
    logic       tx_busy;
    logic       TxD2;
    logic       TBR2;
    logic       tx_busy2;

    int checks   = 0;
    int failures = 0;
    int bper     = 1;
    int bcnt     = 0;

    uart_tx dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .Baud    (Baud),
        .TxD_data(TxD_data),
        .wr_tx   (wr_tx),
        .TxD     (TxD),
        .TBR     (TBR),
        .tx_busy (tx_busy)
    );

    uart_tx #(
        .STOP_BITS(2)
    ) dut2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .Baud    (Baud),
        .TxD_data(TxD_data2),
        .wr_tx   (wr_tx2),
        .TxD     (TxD2),
        .TBR     (TBR2),
        .tx_busy (tx_busy2)
    );

    always #5 clk = ~clk;

    // Baud pulse every bper-th rising edge
    always @(negedge clk) begin
        Baud = (bcnt == 0);
        bcnt = (bcnt + 1) % bper;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit hit");
        $fatal(1);
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic write(input bit sel,
                         input logic [7:0] d);
        if (sel) begin
            TxD_data2 = d;
            wr_tx2    = 1'b1;
        end else begin
            TxD_data  = d;
            wr_tx     = 1'b1;
        end
        step(1);
        wr_tx  = 1'b0;
        wr_tx2 = 1'b0;
    endtask

    task automatic measure(input bit sel,
                           input logic lvl,
                           input int maxc,
                           output int n);
        n = 0;
        while (((sel ? TxD2 : TxD) === lvl) && n < maxc) begin
            n++;
            step(1);
        end
    endtask

    task automatic wait_idle(input bit sel,
                             output bit ok);
        int n;
        n = 0;
        while ((sel ? tx_busy2 : tx_busy) !== 1'b0 && n < 3000) begin
            n++;
            step(1);
        end
        ok = (n < 3000);
    endtask

    task automatic rx_byte(output logic [7:0] b,
                           output logic stp,
                           output bit ok);
        int n;
        n = 0;
        b = 8'hxx;
        stp = 1'bx;
        while (TxD !== 1'b0 && n < 3000) begin
            n++;
            step(1);
        end
        ok = (n < 3000);
        if (ok) begin
            step(8);
            for (int i = 0; i < 8; i++) begin
                step(16);
                b[i] = TxD;
            end
            step(16);
            stp = TxD;
        end
    endtask

    task automatic test_reset;
        step(2);
        checks++;
        if (TxD !== 1'b1) begin
            failures++;
            $display("FAIL reset_txd got=%b exp=1", TxD);
        end
        checks++;
        if (TBR !== 1'b1) begin
            failures++;
            $display("FAIL reset_tbr got=%b exp=1", TBR);
        end
        checks++;
        if (tx_busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy got=%b exp=0", tx_busy);
        end
        rst_n = 1'b1;
        step(2);
    endtask

    task automatic test_reset_mid;
        int bad;
        write(0, 8'h00);
        write(0, 8'h00);
        step(40);
        checks++;
        if (TxD !== 1'b0 || tx_busy !== 1'b1) begin
            failures++;
            $display("FAIL midframe_pre got=%b%b exp=01",
                     TxD, tx_busy);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (TxD !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_txd got=%b exp=1", TxD);
        end
        checks++;
        if (TBR !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_tbr got=%b exp=1", TBR);
        end
        checks++;
        if (tx_busy !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_busy got=%b exp=0", tx_busy);
        end
        step(3);
        rst_n = 1'b1;
        bad = 0;
        repeat (40) begin
            step(1);
            if (TxD !== 1'b1 || tx_busy !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL rst_quiet bad_cycles=%0d exp=0", bad);
        end
    endtask

    task automatic test_single;
        logic [9:0] fr;
        int bad;
        bit ok;
        fr = {1'b1, 8'hA5, 1'b0};
        write(0, 8'hA5);
        checks++;
        if (TBR !== 1'b0 || TxD !== 1'b1) begin
            failures++;
            $display("FAIL single_accept tbr_txd=%b%b exp=01",
                     TBR, TxD);
        end
        step(1);
        checks++;
        if (TBR !== 1'b1 || tx_busy !== 1'b1 || TxD !== 1'b1) begin
            failures++;
            $display("FAIL single_load tbr_busy_txd=%b%b%b exp=111",
                     TBR, tx_busy, TxD);
        end
        step(1);
        for (int i = 0; i < 10; i++) begin
            bad = 0;
            for (int c = 0; c < 16; c++) begin
                if (TxD !== fr[i]) bad++;
                step(1);
            end
            checks++;
            if (bad !== 0) begin
                failures++;
                $display("FAIL single_bit%0d bad_cycles=%0d exp_level=%b",
                         i, bad, fr[i]);
            end
        end
        checks++;
        if (tx_busy !== 1'b0 || TxD !== 1'b1) begin
            failures++;
            $display("FAIL single_end busy_txd=%b%b exp=01",
                     tx_busy, TxD);
        end
        wait_idle(0, ok);
        step(5);
    endtask

    task automatic test_baud_div;
        int n;
        bit ok;
        bper = 4;
        bcnt = 3;
        write(0, 8'h00);
        step(1);
        checks++;
        if (TBR !== 1'b1) begin
            failures++;
            $display("FAIL div_tbr got=%b exp=1", TBR);
        end
        write(0, 8'h00);
        measure(0, 1'b0, 2000, n);
        checks++;
        if (n !== 576) begin
            failures++;
            $display("FAIL div_low1 got=%0d exp=576", n);
        end
        measure(0, 1'b1, 2000, n);
        checks++;
        if (n !== 64) begin
            failures++;
            $display("FAIL div_stop got=%0d exp=64", n);
        end
        measure(0, 1'b0, 2000, n);
        checks++;
        if (n !== 576) begin
            failures++;
            $display("FAIL div_low2 got=%0d exp=576", n);
        end
        wait_idle(0, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL div_idle got=busy exp=idle");
        end
        bper = 1;
        bcnt = 0;
        step(5);
    endtask

    task automatic test_back_to_back;
        int exp_runs[13];
        int n;
        bit ok;
        logic lvl;
        exp_runs = '{16, 16, 16, 16, 16, 16, 16,
                     16, 16, 16, 16, 64, 64};
        write(0, 8'h55);
        step(1);
        write(0, 8'h0F);
        checks++;
        if (TBR !== 1'b0) begin
            failures++;
            $display("FAIL b2b_queued tbr=%b exp=0", TBR);
        end
        lvl = 1'b0;
        for (int i = 0; i < 13; i++) begin
            measure(0, lvl, 200, n);
            checks++;
            if (n !== exp_runs[i]) begin
                failures++;
                $display("FAIL b2b_run%0d level=%b got=%0d exp=%0d",
                         i, lvl, n, exp_runs[i]);
            end
            lvl = ~lvl;
        end
        wait_idle(0, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL b2b_idle got=busy exp=idle");
        end
        step(5);
    endtask

    task automatic test_overrun;
        logic [7:0] b;
        logic stp;
        bit ok;
        write(0, 8'h3C);
        step(1);
        write(0, 8'hC3);
        write(0, 8'hFF);
        checks++;
        if (TBR !== 1'b0) begin
            failures++;
            $display("FAIL ovr_tbr got=%b exp=0", TBR);
        end
        rx_byte(b, stp, ok);
        checks++;
        if (!ok || b !== 8'h3C || stp !== 1'b1) begin
            failures++;
            $display("FAIL ovr_frame1 got=%h stop=%b exp=3c stop=1",
                     b, stp);
        end
        rx_byte(b, stp, ok);
        checks++;
        if (!ok || b !== 8'hC3 || stp !== 1'b1) begin
            failures++;
            $display("FAIL ovr_frame2 got=%h stop=%b exp=c3 stop=1",
                     b, stp);
        end
        wait_idle(0, ok);
        step(40);
        checks++;
        if (TxD !== 1'b1 || tx_busy !== 1'b0) begin
            failures++;
            $display("FAIL ovr_no_third txd_busy=%b%b exp=10",
                     TxD, tx_busy);
        end
    endtask

    task automatic test_two_stop;
        int n;
        bit ok;
        write(1, 8'h80);
        step(1);
        write(1, 8'h80);
        measure(1, 1'b0, 500, n);
        checks++;
        if (n !== 128) begin
            failures++;
            $display("FAIL stop2_low1 got=%0d exp=128", n);
        end
        measure(1, 1'b1, 500, n);
        checks++;
        if (n !== 48) begin
            failures++;
            $display("FAIL stop2_high got=%0d exp=48", n);
        end
        measure(1, 1'b0, 500, n);
        checks++;
        if (n !== 128) begin
            failures++;
            $display("FAIL stop2_low2 got=%0d exp=128", n);
        end
        wait_idle(1, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL stop2_idle got=busy exp=idle");
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_baud_div;
        test_back_to_back;
        test_overrun;
        test_two_stop;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule
